// File: rtl/ccd_cds_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ccd_cds_pkg
// Description : Shared types and constants for the CCD correlated-double-
//               sampling timing block: FSM state encoding, position-index
//               width and default geometry.
// Revision    : 1.0 - initial release
//==============================================================================
package ccd_cds_pkg;

    localparam int unsigned c_IDX_W               = 16;
    localparam int unsigned c_PIX_PER_LINE_DEF    = 1024;
    localparam int unsigned c_LINES_PER_FRAME_DEF = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_R  = 3'd1,
        ST_DLY_REF = 3'd2,
        ST_WAIT_L2 = 3'd3,
        ST_DLY_SIG = 3'd4
    } cds_state_t;

endpackage
`default_nettype wire

// File: rtl/ccd_edge_det.sv
`default_nettype none
//==============================================================================
// Module      : ccd_edge_det
// Description : Falling-edge detector for one CCD clock phase. Optionally
//               re-times the phase through a 2-FF synchronizer first
//               (macro CCD_CDS_SYNC_EN), for a phase generator running in
//               another clock domain.
// Revision    : 1.0 - initial release
// Ports       : i_clk    - system clock, rising edge
//               i_rst_n  - asynchronous active-low reset
//               i_phase  - raw phase input
//               o_fall   - combinational fall flag (prev=1, cur=0)
//==============================================================================
module ccd_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_phase,
    output logic o_fall
);

    logic w_cur;
    logic r_prev;

`ifdef CCD_CDS_SYNC_EN
    // Reset to the idle-high level so leaving reset does not fake an edge
    // inside the synchronizer itself.
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_phase};
        end
    end

    assign w_cur = r_sync[1];
`else
    assign w_cur = i_phase;
`endif

    // Resets to 1: a phase already low out of reset reads as a fall, which
    // the consumer ignores because it is idle at that point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_cur;
        end
    end

    assign o_fall = r_prev & ~w_cur;

endmodule
`default_nettype wire

// File: rtl/ccd_cds_timing.sv
`default_nettype none
//==============================================================================
// Module      : ccd_cds_timing
// Description : Correlated-double-sampling strobe generator. Watches the
//               phi_r and phi_l2 phases and issues a reference-level and a
//               signal-level ADC strobe per pixel after programmable delays,
//               tracks pixel/line position and flags phase overruns.
//               Optional macro CCD_CDS_SYNC_EN adds a 2-FF synchronizer on
//               both phases (all edge-referenced latencies grow by 2).
// Revision    : 1.0 - initial release
// Ports       : i_clk, i_rst_n        - clock / async active-low reset
//               i_enable              - run enable, low forces idle
//               i_phi_r, i_phi_l2     - phases from the phase generator
//               i_dly_ref, i_dly_sig  - fall-to-strobe delays (cycles)
//               o_sample_ref/_sig     - one-cycle ADC strobes
//               o_pix_idx, o_line_idx - position of the pixel being sampled
//               o_line_end/_frame_end - pulses with the last o_sample_sig
//               o_busy                - not idle
//               o_err_overrun         - sticky phase-sequence violation
//==============================================================================
module ccd_cds_timing
    import ccd_cds_pkg::*;
#(
    parameter int unsigned PIX_PER_LINE    = c_PIX_PER_LINE_DEF,
    parameter int unsigned LINES_PER_FRAME = c_LINES_PER_FRAME_DEF,
    parameter int unsigned DLY_W           = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_phi_r,
    input  logic               i_phi_l2,
    input  logic [DLY_W-1:0]   i_dly_ref,
    input  logic [DLY_W-1:0]   i_dly_sig,
    output logic               o_sample_ref,
    output logic               o_sample_sig,
    output logic [c_IDX_W-1:0] o_pix_idx,
    output logic [c_IDX_W-1:0] o_line_idx,
    output logic               o_line_end,
    output logic               o_frame_end,
    output logic               o_busy,
    output logic               o_err_overrun
);

    localparam logic [c_IDX_W-1:0] c_PIX_LAST  = c_IDX_W'(PIX_PER_LINE - 1);
    localparam logic [c_IDX_W-1:0] c_LINE_LAST = c_IDX_W'(LINES_PER_FRAME - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [DLY_W-1:0]   c_DLY_ONE   = DLY_W'(1);

    cds_state_t          r_state;
    logic [DLY_W-1:0]    r_cnt;
    logic                r_enable_d;
    logic                r_sample_ref;
    logic                r_sample_sig;
    logic                r_line_end;
    logic                r_frame_end;
    logic                r_busy;
    logic                r_err;
    logic [c_IDX_W-1:0]  r_pix;
    logic [c_IDX_W-1:0]  r_line;

    logic w_fall_r;
    logic w_fall_l2;
    logic w_ref_start;

    ccd_edge_det u_edge_r (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_phase (i_phi_r),
        .o_fall  (w_fall_r)
    );

    ccd_edge_det u_edge_l2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_phase (i_phi_l2),
        .o_fall  (w_fall_l2)
    );

    // A phi_r fall in any active state starts a pixel; outside WAIT_R it is
    // an overrun that restarts the same pixel. It outranks a coincident
    // phi_l2 fall.
    assign w_ref_start = w_fall_r && (r_state != ST_IDLE);

    // The counter holds (delay - 1) after a load so the strobe lands exactly
    // delay+1 cycles after the fall; a zero delay strobes straight from the
    // load edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_enable_d   <= 1'b0;
            r_sample_ref <= 1'b0;
            r_sample_sig <= 1'b0;
            r_line_end   <= 1'b0;
            r_frame_end  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_pix        <= '0;
            r_line       <= '0;
        end else begin
            r_enable_d   <= i_enable;
            r_sample_ref <= 1'b0;
            r_sample_sig <= 1'b0;
            r_line_end   <= 1'b0;
            r_frame_end  <= 1'b0;

            if (!i_enable) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_pix   <= '0;
                r_line  <= '0;
            end else begin
                r_busy <= 1'b1;
                if (!r_enable_d) begin
                    r_err <= 1'b0;
                end

                // Indices move one cycle after the signal strobe so they are
                // stable while it is high.
                if (r_sample_sig) begin
                    if (r_pix == c_PIX_LAST) begin
                        r_pix  <= '0;
                        r_line <= (r_line == c_LINE_LAST) ? '0 : r_line + c_IDX_ONE;
                    end else begin
                        r_pix <= r_pix + c_IDX_ONE;
                    end
                end

                if (w_ref_start) begin
                    if (r_state != ST_WAIT_R) begin
                        r_err <= 1'b1;
                    end
                    if (i_dly_ref == '0) begin
                        r_sample_ref <= 1'b1;
                        r_state      <= ST_WAIT_L2;
                    end else begin
                        r_cnt   <= i_dly_ref - c_DLY_ONE;
                        r_state <= ST_DLY_REF;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_state <= ST_WAIT_R;
                        end
                        ST_WAIT_R: begin
                            r_state <= ST_WAIT_R;
                        end
                        ST_DLY_REF: begin
                            if (r_cnt == '0) begin
                                r_sample_ref <= 1'b1;
                                r_state      <= ST_WAIT_L2;
                            end else begin
                                r_cnt <= r_cnt - c_DLY_ONE;
                            end
                        end
                        ST_WAIT_L2: begin
                            if (w_fall_l2) begin
                                if (i_dly_sig == '0) begin
                                    r_sample_sig <= 1'b1;
                                    r_line_end   <= (r_pix == c_PIX_LAST);
                                    r_frame_end  <= (r_pix == c_PIX_LAST) && (r_line == c_LINE_LAST);
                                    r_state      <= ST_WAIT_R;
                                end else begin
                                    r_cnt   <= i_dly_sig - c_DLY_ONE;
                                    r_state <= ST_DLY_SIG;
                                end
                            end
                        end
                        ST_DLY_SIG: begin
                            if (r_cnt == '0) begin
                                r_sample_sig <= 1'b1;
                                r_line_end   <= (r_pix == c_PIX_LAST);
                                r_frame_end  <= (r_pix == c_PIX_LAST) && (r_line == c_LINE_LAST);
                                r_state      <= ST_WAIT_R;
                            end else begin
                                r_cnt <= r_cnt - c_DLY_ONE;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign o_sample_ref  = r_sample_ref;
    assign o_sample_sig  = r_sample_sig;
    assign o_pix_idx     = r_pix;
    assign o_line_idx    = r_line;
    assign o_line_end    = r_line_end;
    assign o_frame_end   = r_frame_end;
    assign o_busy        = r_busy;
    assign o_err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ccd_cds_timing.sv
`default_nettype none
//==============================================================================
// Module      : tb_ccd_cds_timing
// Description : Self-checking bench for ccd_cds_timing. A schedule-based
//               model (absolute strobe due-times) predicts every output each
//               cycle; directed scenarios pin exact cycle numbers.
//               Honours CCD_CDS_SYNC_EN (edge latencies +2).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_ccd_cds_timing;

    localparam int PIX   = 4;
    localparam int LINES = 2;
`ifdef CCD_CDS_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic        phi_r  = 1'b1;
    logic        phi_l2 = 1'b1;
    logic [7:0]  dly_ref = 8'd0;
    logic [7:0]  dly_sig = 8'd0;

    logic        sample_ref, sample_sig, line_end, frame_end, busy, err;
    logic [15:0] pix_idx, line_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ccd_cds_timing #(
        .PIX_PER_LINE    (PIX),
        .LINES_PER_FRAME (LINES),
        .DLY_W           (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_phi_r       (phi_r),
        .i_phi_l2      (phi_l2),
        .i_dly_ref     (dly_ref),
        .i_dly_sig     (dly_sig),
        .o_sample_ref  (sample_ref),
        .o_sample_sig  (sample_sig),
        .o_pix_idx     (pix_idx),
        .o_line_idx    (line_idx),
        .o_line_end    (line_end),
        .o_frame_end   (frame_end),
        .o_busy        (busy),
        .o_err_overrun (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected outputs for the current cycle
    logic e_ref = 0, e_sig = 0, e_le = 0, e_fe = 0, e_busy = 0, e_err = 0;
    int   e_pix = 0, e_line = 0;
    // Schedule: absolute cycle a strobe is due (-1 none), waiting for phi_l2
    int   ref_due = -1, sig_due = -1;
    bit   awaiting = 0;
    bit   en_prev = 0;
    // Phase as seen by edge detection (optionally delayed by SL cycles)
    bit   m_prev_r = 1, m_prev_l2 = 1;
    bit   s1_r = 1, s2_r = 1, s1_l2 = 1, s2_l2 = 1;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e_ref = 0; e_sig = 0; e_le = 0; e_fe = 0; e_busy = 0; e_err = 0;
                e_pix = 0; e_line = 0; ref_due = -1; sig_due = -1; awaiting = 0;
                en_prev = 0; m_prev_r = 1; m_prev_l2 = 1;
                s1_r = 1; s2_r = 1; s1_l2 = 1; s2_l2 = 1;
            end else begin
                bit cur_r, cur_l2, fall_r, fall_l2, was_active;
                int c;
                c = cyc;
                cur_r  = (SL == 2) ? s2_r  : phi_r;
                cur_l2 = (SL == 2) ? s2_l2 : phi_l2;
                fall_r  = m_prev_r  && !cur_r;
                fall_l2 = m_prev_l2 && !cur_l2;
                m_prev_r = cur_r;  s2_r = s1_r;   s1_r = phi_r;
                m_prev_l2 = cur_l2; s2_l2 = s1_l2; s1_l2 = phi_l2;

                if (!enable) begin
                    e_ref = 0; e_sig = 0; e_le = 0; e_fe = 0; e_busy = 0;
                    e_pix = 0; e_line = 0; ref_due = -1; sig_due = -1; awaiting = 0;
                end else begin
                    if (!en_prev) e_err = 0;
                    was_active = e_busy;
                    if (e_sig) begin
                        e_pix = e_pix + 1;
                        if (e_pix == PIX) begin
                            e_pix = 0;
                            e_line = (e_line + 1) % LINES;
                        end
                    end
                    e_ref = 0; e_sig = 0; e_le = 0; e_fe = 0;
                    if (was_active && fall_r) begin
                        if (ref_due >= 0 || awaiting || sig_due >= 0) e_err = 1;
                        ref_due  = c + 1 + int'(dly_ref);
                        sig_due  = -1;
                        awaiting = 0;
                    end else if (was_active && awaiting && fall_l2) begin
                        sig_due  = c + 1 + int'(dly_sig);
                        awaiting = 0;
                    end
                    if (ref_due == c + 1) begin
                        e_ref = 1; ref_due = -1; awaiting = 1;
                    end
                    if (sig_due == c + 1) begin
                        e_sig = 1; sig_due = -1;
                        e_le = (e_pix == PIX - 1);
                        e_fe = e_le && (e_line == LINES - 1);
                    end
                    e_busy = 1;
                end
                en_prev = enable;
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_sample_ref", sample_ref, 0);
                chk("rst_sample_sig", sample_sig, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
                chk("rst_pix", pix_idx, 0);
                chk("rst_line", line_idx, 0);
                chk("rst_line_end", line_end, 0);
                chk("rst_frame_end", frame_end, 0);
            end else begin
                chk("sample_ref", sample_ref, e_ref);
                chk("sample_sig", sample_sig, e_sig);
                chk("line_end", line_end, e_le);
                chk("frame_end", frame_end, e_fe);
                chk("busy", busy, e_busy);
                chk("err_overrun", err, e_err);
                chk("pix_idx", pix_idx, e_pix);
                chk("line_idx", line_idx, e_line);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int ref_at, ref2_at, sig_at, pix1_at, nref, nsig, err_at, busy1;
        int pix_at_ref2, busy9, pix9, err9, err12, err13, busy13, busy_pre, pix_pre;
        logic [7:0] le_mask, fe_mask;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_pix", pix_idx, 0);
        chk("reset_line", line_idx, 0);
        chk("reset_err", err, 0);

        // Nominal pixel: enable in cycle 0, phi_r falls at 10, phi_l2 at 30
        enable = 1; dly_ref = 8'd3; dly_sig = 8'd5;
        ref_at = -1; sig_at = -1; pix1_at = -1; nref = 0; nsig = 0; busy1 = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            phi_r  = (k == 10) ? 1'b0 : 1'b1;
            phi_l2 = (k == 30) ? 1'b0 : 1'b1;
            if (k == 12) dly_ref = 8'd7;   // mid-count change must not matter
            if (k == 1) busy1 = int'(busy);
            if (sample_ref) begin nref++; ref_at = k; end
            if (sample_sig) begin nsig++; sig_at = k; end
            if (pix_idx == 16'd1 && pix1_at < 0) pix1_at = k;
        end
        chk("nom_busy_after_enable", busy1, 1);
        chk("nom_ref_cycle", ref_at, 14 + SL);
        chk("nom_ref_count", nref, 1);
        chk("nom_sig_cycle", sig_at, 36 + SL);
        chk("nom_sig_count", nsig, 1);
        chk("nom_pix_advance_cycle", pix1_at, 37 + SL);

        // Zero delay: strobes one cycle after each fall
        dly_ref = 8'd0; dly_sig = 8'd0;
        ref_at = -1; sig_at = -1; pix1_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            phi_r  = (k == 2) ? 1'b0 : 1'b1;
            phi_l2 = (k == 6) ? 1'b0 : 1'b1;
            if (sample_ref) ref_at = k;
            if (sample_sig) sig_at = k;
            if (pix_idx == 16'd2 && pix1_at < 0) pix1_at = k;
        end
        chk("zero_ref_cycle", ref_at, 3 + SL);
        chk("zero_sig_cycle", sig_at, 7 + SL);
        chk("zero_pix_advance_cycle", pix1_at, 8 + SL);

        // Line/frame wrap: 8 pixels from a cleared position
        enable = 0; tick();
        enable = 1; tick();
        le_mask = '0; fe_mask = '0; nsig = 0;
        dly_ref = 8'd1; dly_sig = 8'd2;
        for (int p = 0; p < 8; p++) begin
            for (int k = 1; k <= 14; k++) begin
                tick();
                phi_r  = (k == 1) ? 1'b0 : 1'b1;
                phi_l2 = (k == 6) ? 1'b0 : 1'b1;
                if (sample_sig) begin
                    nsig++;
                    if (line_end)  le_mask[p] = 1'b1;
                    if (frame_end) fe_mask[p] = 1'b1;
                end
            end
        end
        chk("wrap_sig_count", nsig, 8);
        chk("wrap_line_end_mask", le_mask, 8'h88);
        chk("wrap_frame_end_mask", fe_mask, 8'h80);
        chk("wrap_pix_final", pix_idx, 0);
        chk("wrap_line_final", line_idx, 0);

        // Overrun: second phi_r fall while waiting for phi_l2
        dly_ref = 8'd2; dly_sig = 8'd2;
        ref_at = -1; ref2_at = -1; sig_at = -1; nref = 0; nsig = 0; err_at = -1;
        pix_at_ref2 = -1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            phi_r  = (k == 1 || k == 8) ? 1'b0 : 1'b1;
            phi_l2 = (k == 14) ? 1'b0 : 1'b1;
            if (err && err_at < 0) err_at = k;
            if (sample_ref) begin
                nref++;
                if (nref == 1) ref_at = k;
                else begin ref2_at = k; pix_at_ref2 = int'(pix_idx); nsig = 0 + nsig; end
            end
            if (sample_sig) begin
                if (ref2_at < 0) nsig = nsig + 100;  // sig before restart is an error
                else nsig++;
                sig_at = k;
            end
        end
        chk("ovr_first_ref", ref_at, 4 + SL);
        chk("ovr_err_cycle", err_at, 9 + SL);
        chk("ovr_restart_ref", ref2_at, 11 + SL);
        chk("ovr_pix_at_restart", pix_at_ref2, 0);
        chk("ovr_sig_count", nsig, 1);
        chk("ovr_sig_cycle", sig_at, 17 + SL);
        chk("ovr_err_sticky", err, 1);

        // Abort during DLY_SIG, then re-enable clears the error
        dly_ref = 8'd1; dly_sig = 8'd6; nsig = 0;
        busy9 = -1; pix9 = -1; err9 = -1; err12 = -1; err13 = -1; busy13 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            phi_r  = (k == 1) ? 1'b0 : 1'b1;
            phi_l2 = (k == 5) ? 1'b0 : 1'b1;
            enable = (k >= 8 && k < 12) ? 1'b0 : 1'b1;
            if (sample_sig) nsig++;
            if (k == 9)  begin busy9 = int'(busy); pix9 = int'(pix_idx); err9 = int'(err); end
            if (k == 12) err12 = int'(err);
            if (k == 13) begin err13 = int'(err); busy13 = int'(busy); end
        end
        chk("abort_no_sig", nsig, 0);
        chk("abort_busy_low", busy9, 0);
        chk("abort_pix_cleared", pix9, 0);
        chk("abort_err_held", err9, 1);
        chk("reenable_err_still_set", err12, 1);
        chk("reenable_err_cleared", err13, 0);
        chk("reenable_busy", busy13, 1);

        // Reset asserted mid-count clears outputs immediately
        busy_pre = -1; pix_pre = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            dly_ref = (k < 8) ? 8'd0 : 8'd9;
            dly_sig = 8'd0;
            phi_r  = (k == 1 || k == 8) ? 1'b0 : 1'b1;
            phi_l2 = (k == 3) ? 1'b0 : 1'b1;
        end
        busy_pre = int'(busy); pix_pre = int'(pix_idx);
        rst_n = 1'b0;
        #2;
        chk("midrst_busy_before", busy_pre, 1);
        chk("midrst_pix_before", pix_pre, 1);
        chk("midrst_busy_now", busy, 0);
        chk("midrst_pix_now", pix_idx, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Randomized phases, delays and enable
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 59) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            phi_r   = ($urandom_range(0, 11) != 0);
            phi_l2  = ($urandom_range(0, 3) != 0);
            dly_ref = 8'($urandom_range(0, 7));
            dly_sig = 8'($urandom_range(0, 7));
        end
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
